// File: rtl/thresholding_pkg.sv
`default_nettype none
// thresholding_pkg: shared types and sizing helpers for the thresholding stream controller.
package thresholding_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_DRAIN  = 2'd1,
    CFG_LOAD   = 2'd2,
    CFG_SETTLE = 2'd3
  } cfg_state_e;

  // Channel index width; a single channel still needs one bit on the ports.
  function automatic int c_bits(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  function automatic int thresh_cnt(input int n);
    return (1 << n) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/thresholding_ofifo.sv
`default_nettype none
// thresholding_ofifo: first-word-fall-through FIFO with occupancy count.
module thresholding_ofifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;

  assign do_pop = pop && (cnt != '0);
  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign count  = cnt;
  assign dout   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/thresholding_stream_ctrl.sv
`default_nettype none
// thresholding_stream_ctrl: credit-based AXI-Stream front/back end for the thresholding core.
// Threshold loader sequencer is built only when THRESHOLDING_CFG_LOADER_EN is defined.
module thresholding_stream_ctrl
  import thresholding_pkg::*;
#(
  parameter int N          = 4,
  parameter int M          = 8,
  parameter int C          = 1,
  parameter int O_BITS     = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int C_BITS    = c_bits(C),
  localparam int TWA_W     = $clog2(C) + N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [M-1:0]      s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [O_BITS-1:0] m_tdata,
  output logic [C_BITS-1:0] m_tchan,
  output logic              core_en,
  output logic              core_ivld,
  output logic [C_BITS-1:0] core_icnl,
  output logic [M-1:0]      core_idat,
  input  logic              core_ovld,
  input  logic [C_BITS-1:0] core_ocnl,
  input  logic [O_BITS-1:0] core_odat,
  input  logic              cfg_tvalid,
  output logic              cfg_tready,
  input  logic [M-1:0]      cfg_tdata,
  output logic              core_twe,
  output logic [TWA_W-1:0]  core_twa,
  output logic [M-1:0]      core_twd,
  output logic              cfg_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [C_BITS-1:0] chan;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  occ;
  logic              accept;
  logic              pop;
  logic              credit_ok;
  logic              cfg_block;
  logic              fifo_empty;
  logic              fifo_full;

  // Every accepted beat reserves a FIFO slot until its result lands, so a push never overflows.
  assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
  assign s_tready  = !rst && credit_ok && !cfg_block;
  assign accept    = s_tvalid && s_tready;
  assign core_en   = !rst;
  assign core_ivld = accept;
  assign core_icnl = accept ? chan : '0;
  assign core_idat = accept ? s_tdata : '0;
  assign m_tvalid  = !fifo_empty;
  assign pop       = m_tvalid && m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan     <= '0;
      inflight <= '0;
    end else begin
      if (accept) chan <= (chan == C_BITS'(C-1)) ? '0 : chan + 1'b1;
      case ({accept, core_ovld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  thresholding_ofifo #(
    .WIDTH(C_BITS + O_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_ofifo (
    .clk  (clk),
    .rst  (rst),
    .push (core_ovld),
    .din  ({core_ocnl, core_odat}),
    .pop  (pop),
    .dout ({m_tchan, m_tdata}),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(occ)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(core_ovld && fifo_full && !pop));

`ifdef THRESHOLDING_CFG_LOADER_EN
  localparam logic [1:0] ST_IDLE   = 2'(CFG_IDLE);
  localparam logic [1:0] ST_DRAIN  = 2'(CFG_DRAIN);
  localparam logic [1:0] ST_LOAD   = 2'(CFG_LOAD);
  localparam logic [1:0] ST_SETTLE = 2'(CFG_SETTLE);

  logic [1:0]        state;
  logic [C_BITS-1:0] cnl;
  logic [N-1:0]      j;

  assign cfg_block  = (state != ST_IDLE);
  assign cfg_tready = (state == ST_LOAD);
  assign cfg_done   = (state == ST_SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnl      <= '0;
      j        <= '0;
      core_twe <= 1'b0;
      core_twa <= '0;
      core_twd <= '0;
    end else begin
      core_twe <= 1'b0;
      case (state)
        ST_IDLE:  if (cfg_tvalid) state <= ST_DRAIN;
        // Thresholds may only change once no beat is still inside the core.
        ST_DRAIN: if (inflight == '0) state <= ST_LOAD;
        ST_LOAD: begin
          if (cfg_tvalid) begin
            core_twe <= 1'b1;
            core_twd <= cfg_tdata;
            core_twa <= TWA_W'({cnl, j});
            if (j == N'(thresh_cnt(N) - 1)) begin
              j <= '0;
              if (cnl == C_BITS'(C-1)) begin
                cnl   <= '0;
                state <= ST_SETTLE;
              end else begin
                cnl <= cnl + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg_tvalid, cfg_tdata};
  assign cfg_block  = 1'b0;
  assign cfg_tready = 1'b0;
  assign cfg_done   = 1'b0;
  assign core_twe   = 1'b0;
  assign core_twa   = '0;
  assign core_twd   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thresholding_stream_ctrl.sv
`default_nettype none
// tb_thresholding_stream_ctrl: directed bench with a behavioural thresholding core (N=2, C=2, depth 4).
module tb_thresholding_stream_ctrl;

  localparam int N = 2;
  localparam int M = 8;
  localparam int C = 2;
  localparam int O_BITS = 4;
  localparam int FIFO_DEPTH = 4;

  logic clk, rst;
  logic s_tvalid, s_tready, m_tvalid, m_tready;
  logic [7:0] s_tdata;
  logic [3:0] m_tdata;
  logic [0:0] m_tchan;
  logic core_en, core_ivld, core_ovld;
  logic [0:0] core_icnl, core_ocnl;
  logic [7:0] core_idat;
  logic [3:0] core_odat;
  logic cfg_tvalid, cfg_tready, cfg_done, core_twe;
  logic [7:0] cfg_tdata, core_twd;
  logic [2:0] core_twa;

  thresholding_stream_ctrl #(.N(N), .M(M), .C(C), .O_BITS(O_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tchan(m_tchan),
    .core_en(core_en), .core_ivld(core_ivld), .core_icnl(core_icnl), .core_idat(core_idat),
    .core_ovld(core_ovld), .core_ocnl(core_ocnl), .core_odat(core_odat),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
    .core_twe(core_twe), .core_twa(core_twa), .core_twd(core_twd), .cfg_done(cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: counts thresholds t with x >= t, latency N, reset with the controller.
  logic signed [7:0] thr [8];
  logic       bk_we = 1'b0;
  logic [2:0] bk_addr = '0;
  logic [7:0] bk_data = '0;
  logic [1:0] p_vld;
  logic       p_cnl0, p_cnl1;
  logic [3:0] p_dat0, p_dat1;
  int         ovld_cnt = 0;

  function automatic logic [3:0] core_cnt(input logic ch, input logic [7:0] x);
    logic [3:0] n;
    n = 0;
    for (int k = 0; k < 3; k++) if ($signed(x) >= thr[{ch, 2'(k)}]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (core_twe) thr[core_twa] <= core_twd;
    else if (bk_we) thr[bk_addr] <= bk_data;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= 2'b00; p_cnl0 <= 1'b0; p_cnl1 <= 1'b0; p_dat0 <= '0; p_dat1 <= '0;
    end else if (core_en) begin
      p_vld  <= {p_vld[0], core_ivld};
      p_cnl0 <= core_icnl[0];
      p_dat0 <= core_cnt(core_icnl[0], core_idat);
      p_cnl1 <= p_cnl0;
      p_dat1 <= p_dat0;
    end
  end

  assign core_ovld = p_vld[1];
  assign core_ocnl = p_cnl1;
  assign core_odat = p_dat1;

  always @(posedge clk) if (core_ovld) ovld_cnt <= ovld_cnt + 1;

  // Bench-side reference table, scoreboard and bookkeeping.
  logic signed [7:0] ref_thr [8];
  logic signed [7:0] cfg_vals [6];
  logic [2:0] twa_exp [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  logic [4:0] exp_q [$];
  logic [4:0] pop_log [$];
  logic exp_chan;
  logic last_mv, last_acc;
  int n_acc, n_pop, checks, fails;

  function automatic logic [3:0] ref_cnt(input logic ch, input logic [7:0] x);
    logic [3:0] n;
    n = 0;
    for (int k = 0; k < 3; k++) if ($signed(x) >= ref_thr[{ch, 2'(k)}]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc, pp;
    logic [4:0] got;
    @(negedge clk);
    acc = s_tvalid && s_tready;
    pp  = m_tvalid && m_tready;
    last_mv = m_tvalid;
    last_acc = acc;
    if (acc) begin
      check("ivld", core_ivld, 1);
      check("icnl", core_icnl, exp_chan);
      check("idat", core_idat, s_tdata);
      exp_q.push_back({exp_chan, ref_cnt(exp_chan, s_tdata)});
      exp_chan = ~exp_chan;
      n_acc++;
    end
    if (pp) begin
      got = {m_tchan, m_tdata};
      pop_log.push_back(got);
      n_pop++;
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_data", got, exp_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_tables(input logic signed [7:0] a0, a1, a2, b0, b1, b2);
    cfg_vals[0] = a0; cfg_vals[1] = a1; cfg_vals[2] = a2;
    cfg_vals[3] = b0; cfg_vals[4] = b1; cfg_vals[5] = b2;
  endtask

`ifdef THRESHOLDING_CFG_LOADER_EN
  task automatic load_table();
    int idx, dones;
    logic hs;
    idx = 0; dones = 0;
    cfg_tvalid = 1'b1; cfg_tdata = cfg_vals[0];
    for (int n = 0; n < 60 && idx < 6; n++) begin
      @(negedge clk);
      hs = cfg_tready;
      if (cfg_done) dones++;
      if (hs) check("ld_s_tready_blocked", s_tready, 0);
      @(posedge clk); #1;
      if (hs) begin
        check("ld_twe", core_twe, 1);
        check("ld_twa", core_twa, twa_exp[idx]);
        check("ld_twd", core_twd, cfg_vals[idx]);
        idx++;
        if (idx < 6) cfg_tdata = cfg_vals[idx];
        else cfg_tvalid = 1'b0;
      end
    end
    cfg_tvalid = 1'b0;
    check("ld_beats", idx, 6);
    check("ld_done_early", dones, 0);
    @(negedge clk);
    check("settle_done", cfg_done, 1);
    check("settle_s_tready", s_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_done", cfg_done, 0);
    check("idle_s_tready", s_tready, 1);
    check("idle_twe", core_twe, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) ref_thr[twa_exp[k]] = cfg_vals[k];
  endtask
`else
  task automatic load_table();
    cfg_tvalid = 1'b1; cfg_tdata = cfg_vals[0];
    for (int k = 0; k < 6; k++) begin
      bk_we = 1'b1; bk_addr = twa_exp[k]; bk_data = cfg_vals[k];
      @(negedge clk);
      check("nold_cfg_tready", cfg_tready, 0);
      check("nold_twe", core_twe, 0);
      check("nold_done", cfg_done, 0);
      @(posedge clk); #1;
    end
    bk_we = 1'b0;
    @(negedge clk);
    check("nold_s_tready", s_tready, 1);
    cfg_tvalid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) ref_thr[twa_exp[k]] = cfg_vals[k];
  endtask
`endif

  initial begin
    int first_mv, a0, guard;
    logic seen_mv;
    checks = 0; fails = 0; n_acc = 0; n_pop = 0; exp_chan = 1'b0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    cfg_tvalid = 1'b0; cfg_tdata = '0;
    for (int k = 0; k < 8; k++) ref_thr[k] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_core_en", core_en, 0);
    check("rst_cfg_tready", cfg_tready, 0);
    check("rst_m_tdata", m_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("core_en_on", core_en, 1);
    check("idle_ivld", core_ivld, 0);
    @(posedge clk); #1;

    // 1. Reset mid-stream
    a0 = n_acc;
    s_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin s_tdata = 8'(5 + k); tick(); end
    check("t1_accepts", n_acc - a0, 3);
    rst = 1'b1;
    #1;
    check("t1_rst_m_tvalid", m_tvalid, 0);
    check("t1_rst_s_tready", s_tready, 0);
    s_tvalid = 1'b0;
    exp_q.delete(); pop_log.delete(); exp_chan = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'd9;
    #1;
    check("t1_s_tready", s_tready, 1);
    check("t1_chan0", core_icnl, 0);
    check("t1_ivld", core_ivld, 1);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    seen_mv = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); if (last_mv) seen_mv = 1'b1; end
    check("t1_flushed", seen_mv, 0);
    m_tready = 1'b0;

    // 2. Load ch0={-4,0,4}, ch1={10,20,30}
    set_tables(-8'sd4, 8'sd0, 8'sd4, 8'sd10, 8'sd20, 8'sd30);
    load_table();

    // 3. Inputs 0,25,-5,30 with latency check
    pop_log.delete();
    m_tready = 1'b1;
    first_mv = -1;
    a0 = n_acc;
    for (int k = 0; k < 10; k++) begin
      s_tvalid = (k < 4);
      case (k)
        0: s_tdata = 8'd0;
        1: s_tdata = 8'd25;
        2: s_tdata = 8'(-5);
        default: s_tdata = 8'd30;
      endcase
      tick();
      if (last_mv && first_mv < 0) first_mv = k;
    end
    s_tvalid = 1'b0;
    check("t3_accepts", n_acc - a0, 4);
    check("t3_latency", first_mv, 3);
    check("t3_npop", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
      check("t3_out0", pop_log[0], 5'h02);
      check("t3_out1", pop_log[1], 5'h12);
      check("t3_out2", pop_log[2], 5'h00);
      check("t3_out3", pop_log[3], 5'h13);
    end

    // 4. Backpressure: 10 beats offered, 4 taken
    m_tready = 1'b0;
    a0 = n_acc;
    s_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin s_tdata = 8'(k + 1); tick(); end
    check("t4_accepts", n_acc - a0, 4);
    check("t4_last_blocked", last_acc, 0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    a0 = n_pop;
    for (int k = 0; k < 8; k++) tick();
    check("t4_drained", n_pop - a0, 4);
    check("t4_sb_empty", exp_q.size(), 0);

    // 5. Config request with two beats still inside the core
    m_tready = 1'b0;
    pop_log.delete();
    s_tvalid = 1'b1;
    s_tdata = 8'd15; tick();
    s_tdata = 8'd25; tick();
    s_tvalid = 1'b0;
    set_tables(8'sd1, 8'sd2, 8'sd3, -8'sd10, -8'sd5, 8'sd0);
`ifdef THRESHOLDING_CFG_LOADER_EN
    a0 = ovld_cnt;
    cfg_tvalid = 1'b1; cfg_tdata = cfg_vals[0];
    guard = 0;
    @(negedge clk);
    while (!cfg_tready && guard < 20) begin
      @(posedge clk); #1; @(negedge clk); guard++;
    end
    cfg_tvalid = 1'b0;
    check("t5_cfg_ready_seen", cfg_tready, 1);
    check("t5_drained_before_load", ovld_cnt - a0, 2);
    check("t5_fifo_kept", m_tvalid, 1);
    @(posedge clk); #1;
`endif
    load_table();
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t5_npop", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("t5_old0", pop_log[0], 5'h03);
      check("t5_old1", pop_log[1], 5'h12);
    end

    // 6. Random valid/ready traffic
    a0 = n_acc;
    guard = 0;
    while ((n_acc - a0) < 1000 && guard < 20000) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = 8'($urandom);
      m_tready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    check("t6_accepted", n_acc - a0, 1000);
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("t6_sb_empty", exp_q.size(), 0);

    a0 = n_acc;
    s_tvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin s_tdata = 8'($urandom); tick(); end
    check("t6_throughput", n_acc - a0, 12);
    s_tvalid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("t6_burst_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
